// File: rtl/blake_msg_host_if.sv
// Byte-stream, hasher-control and digest-handshake bundle for blake_msg_host.
// master = upstream source / hasher / digest consumer side, slave = blake_msg_host.
interface blake_msg_host_if #(
  parameter int W = 32
);
  logic [7:0]     s_data;
  logic           s_valid;
  logic           s_last;
  logic           s_empty;
  logic           s_ready;
  logic [7:0]     data_out;
  logic           dv_out;
  logic           drdy_in;
  logic           start_out;
  logic           finish_out;
  logic [7:0]     hd_in;
  logic           hdv_in;
  logic           hend_in;
  logic [W*8-1:0] digest;
  logic           digest_valid;
  logic           digest_ack;
  logic [W*2-1:0] msg_len;
  logic           busy;
  logic           err;

  modport master (
    output s_data, s_valid, s_last, s_empty, drdy_in, hd_in, hdv_in, hend_in, digest_ack,
    input  s_ready, data_out, dv_out, start_out, finish_out, digest, digest_valid, msg_len, busy, err
  );

  modport slave (
    input  s_data, s_valid, s_last, s_empty, drdy_in, hd_in, hdv_in, hend_in, digest_ack,
    output s_ready, data_out, dv_out, start_out, finish_out, digest, digest_valid, msg_len, busy, err
  );
endinterface

// File: rtl/blake_msg_host.sv
// Host-side front end for the BLAKE2 data manager: streams a message into the hasher and gathers the digest.
// Optional WAIT_DIG watchdog is built when BLAKE_MSG_HOST_TIMEOUT_EN is defined.
module blake_msg_host #(
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  blake_msg_host_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    STREAM   = 3'd2,
    WAIT_DIG = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam int CW = $clog2(W + 1);
  localparam int LW = W * 2;

  state_t         state_r;
  logic [CW-1:0]  cnt_r;
  logic [W*8-1:0] digest_r;
  logic [LW-1:0]  msg_len_r;
  logic           start_r;
  logic           fin_r;
  logic           dvalid_r;
  logic           busy_r;
  logic           err_r;
  logic           acc_s;

`ifdef BLAKE_MSG_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]  wd_r;
`else
  logic           timeout_unused_s;
  assign timeout_unused_s = (TIMEOUT > 0);
`endif

  // Upstream is only opened while streaming, and then mirrors the hasher's ready.
  always_comb begin
    bus.s_ready = 1'b0;
    if (state_r == STREAM) begin
      bus.s_ready = bus.drdy_in;
    end else begin
      bus.s_ready = 1'b0;
    end
  end

  assign acc_s            = bus.s_valid & bus.s_ready;
  assign bus.data_out     = bus.s_data;
  assign bus.dv_out       = acc_s & ~bus.s_empty;
  // Finish leads the register by one cycle so it coincides with the last beat.
  assign bus.finish_out   = fin_r | (acc_s & bus.s_last);
  assign bus.start_out    = start_r;
  assign bus.digest       = digest_r;
  assign bus.digest_valid = dvalid_r;
  assign bus.msg_len      = msg_len_r;
  assign bus.busy         = busy_r;
  assign bus.err          = err_r;

  // Control FSM with message counter, digest assembly and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      digest_r  <= '0;
      msg_len_r <= '0;
      start_r   <= 1'b0;
      fin_r     <= 1'b0;
      dvalid_r  <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
`ifdef BLAKE_MSG_HOST_TIMEOUT_EN
      wd_r      <= '0;
`endif
    end else begin
      start_r <= 1'b0;
      if (bus.hdv_in && (state_r != WAIT_DIG)) begin
        err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (bus.s_valid) begin
            state_r <= START;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
          end
        end
        START: begin
          msg_len_r <= '0;
          digest_r  <= '0;
          cnt_r     <= '0;
          // A stray digest byte in this very cycle still gets reported.
          if (!bus.hdv_in) begin
            err_r <= 1'b0;
          end
`ifdef BLAKE_MSG_HOST_TIMEOUT_EN
          wd_r      <= '0;
`endif
          state_r   <= STREAM;
        end
        STREAM: begin
          if (acc_s) begin
            if (!bus.s_empty) begin
              msg_len_r <= msg_len_r + LW'(1);
            end else if (!bus.s_last) begin
              err_r <= 1'b1;
            end
            if (bus.s_last) begin
              fin_r   <= 1'b1;
              state_r <= WAIT_DIG;
            end
          end
        end
        WAIT_DIG: begin
          if (bus.hdv_in) begin
            if (cnt_r < CW'(W)) begin
              for (int k = 0; k < W; k++) begin
                if (cnt_r == CW'(k)) begin
                  digest_r[k*8 +: 8] <= bus.hd_in;
                end
              end
              cnt_r <= cnt_r + CW'(1);
            end else begin
              err_r <= 1'b1;
            end
            if (bus.hend_in) begin
              if (cnt_r != CW'(W - 1)) begin
                err_r <= 1'b1;
              end
              fin_r    <= 1'b0;
              dvalid_r <= 1'b1;
              state_r  <= DONE;
            end
          end
`ifdef BLAKE_MSG_HOST_TIMEOUT_EN
          if (bus.hdv_in) begin
            wd_r <= '0;
          end else if (wd_r == TW'(TIMEOUT - 1)) begin
            err_r    <= 1'b1;
            fin_r    <= 1'b0;
            dvalid_r <= 1'b1;
            state_r  <= DONE;
            wd_r     <= '0;
          end else begin
            wd_r <= wd_r + TW'(1);
          end
`endif
        end
        DONE: begin
          if (bus.digest_ack) begin
            dvalid_r <= 1'b0;
            busy_r   <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          fin_r    <= 1'b0;
          dvalid_r <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_blake_msg_host.sv
// Self-checking bench for blake_msg_host: random messages and digests against a queue-based reference model.
module tb_blake_msg_host;
  localparam int W  = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       empty;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  blake_msg_host_if #(.W(W)) bus ();
  blake_msg_host #(.W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;

  beat_t      msg_q[$];
  logic [7:0] dig_q[$];
  logic [7:0] mon_bytes[$];
  int         cyc = 0;
  int         start_cnt, start_cyc, first_dv, last_dv, fin_rises, fin_viol, stall_viol;
  logic       fin_rise_dv;
  logic [7:0] fin_rise_data;
  logic       fin_prev = 1'b0;

  // Passive observer of the hasher-facing side, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.start_out === 1'b1) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (bus.dv_out === 1'b1) begin
        mon_bytes.push_back(bus.data_out);
        if (first_dv < 0) first_dv = cyc;
        last_dv = cyc;
      end
      if (bus.finish_out === 1'b1 && !fin_prev) begin
        fin_rise_dv   = bus.dv_out;
        fin_rise_data = bus.data_out;
        fin_rises++;
      end
      if (fin_prev && bus.finish_out === 1'b0 && bus.digest_valid === 1'b0 && bus.busy === 1'b1) fin_viol++;
      if (bus.finish_out === 1'b1 && bus.digest_valid === 1'b1) fin_viol++;
      if (bus.drdy_in === 1'b0 && (bus.s_ready === 1'b1 || bus.dv_out === 1'b1)) stall_viol++;
    end
    fin_prev = (bus.finish_out === 1'b1);
  end

  function automatic beat_t mk(input logic [7:0] d, input logic last, input logic empty);
    beat_t b;
    b.d = d; b.last = last; b.empty = empty;
    return b;
  endfunction

  // Reference model: the hasher sees exactly the non-empty beats, in order.
  function automatic bit stream_ok();
    int j = 0;
    foreach (msg_q[i]) begin
      if (!msg_q[i].empty) begin
        if (j >= mon_bytes.size()) return 1'b0;
        if (mon_bytes[j] !== msg_q[i].d) return 1'b0;
        j++;
      end
    end
    return (j == mon_bytes.size());
  endfunction

  function automatic logic [W*2-1:0] exp_len();
    int n = 0;
    foreach (msg_q[i]) if (!msg_q[i].empty) n++;
    return (W*2)'(n);
  endfunction

  function automatic bit exp_msg_err();
    foreach (msg_q[i]) if (msg_q[i].empty && !msg_q[i].last) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [W*8-1:0] exp_digest(input int hend_i);
    logic [W*8-1:0] d = '0;
    for (int k = 0; k <= hend_i && k < W; k++) d[k*8 +: 8] = dig_q[k];
    return d;
  endfunction

  task automatic clear_mon();
    mon_bytes.delete();
    start_cnt = 0; start_cyc = -1; first_dv = -1; last_dv = -1;
    fin_rises = 0; fin_viol = 0; stall_viol = 0;
    fin_rise_dv = 1'b0; fin_rise_data = 8'h00;
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(mk(8'h61, 1'b0, 1'b0));
    msg_q.push_back(mk(8'h62, 1'b0, 1'b0));
    msg_q.push_back(mk(8'h63, 1'b1, 1'b0));
  endtask

  task automatic load_digest(input int n, input bit counting);
    dig_q.delete();
    for (int k = 0; k < n; k++) dig_q.push_back(counting ? 8'(k) : 8'($urandom_range(0, 255)));
  endtask

  task automatic send_msg(input bit rand_rdy, input int stall_at, input int stall_len, output bit ok);
    int i = 0;
    int guard = 0;
    int stalled = 0;
    @(posedge clk); #1;
    while (i < msg_q.size() && guard < 2000) begin
      bus.s_valid = 1'b1;
      bus.s_data  = msg_q[i].d;
      bus.s_last  = msg_q[i].last;
      bus.s_empty = msg_q[i].empty;
      if (i == stall_at && stalled < stall_len && bus.busy === 1'b1 && bus.start_out === 1'b0) begin
        bus.drdy_in = 1'b0;
        stalled++;
      end else begin
        bus.drdy_in = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(negedge clk);
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_empty = 1'b0; bus.drdy_in = 1'b1;
    ok = (i == msg_q.size());
  endtask

  task automatic send_digest(input int hend_i, input bit gaps);
    for (int k = 0; k <= hend_i; k++) begin
      if (gaps) begin
        bus.hdv_in = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.hdv_in  = 1'b1;
      bus.hd_in   = dig_q[k];
      bus.hend_in = (k == hend_i);
      @(posedge clk); #1;
    end
    bus.hdv_in = 1'b0; bus.hend_in = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < limit; c++) begin
      @(negedge clk);
      if (bus.digest_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic ack_digest();
    @(posedge clk); #1; bus.digest_ack = 1'b1;
    @(posedge clk); #1; bus.digest_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({bus.s_ready, bus.dv_out, bus.start_out, bus.finish_out, bus.digest_valid, bus.busy, bus.err} !== 7'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b required 0000000", {bus.s_ready, bus.dv_out, bus.start_out, bus.finish_out, bus.digest_valid, bus.busy, bus.err}); end
    n_checks++; if (bus.digest !== '0) begin n_fail++; $display("FAIL reset_digest: got %h required 0", bus.digest); end
    n_checks++; if (bus.msg_len !== '0) begin n_fail++; $display("FAIL reset_msg_len: got %0d required 0", bus.msg_len); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.start_out !== 1'b0) begin n_fail++; $display("FAIL reset_release: busy %b start %b required 0 0", bus.busy, bus.start_out); end
  endtask

  task automatic test_abc();
    bit ok1, ok2;
    load_abc(); load_digest(W, 1'b1); clear_mon();
    send_msg(1'b0, -1, 0, ok1); send_digest(W - 1, 1'b0); wait_done(100, ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL abc_timeout: sent %b done %b required 1 1", ok1, ok2); end
    n_checks++; if (start_cnt !== 1) begin n_fail++; $display("FAIL abc_start_pulses: got %0d required 1", start_cnt); end
    n_checks++; if (!stream_ok()) begin n_fail++; $display("FAIL abc_bytes: got %0d bytes, required 61 62 63", mon_bytes.size()); end
    n_checks++; if (first_dv !== start_cyc + 1 || last_dv !== start_cyc + 3) begin n_fail++; $display("FAIL abc_latency: dv cycles %0d..%0d start %0d", first_dv, last_dv, start_cyc); end
    n_checks++; if (fin_rises !== 1 || fin_rise_dv !== 1'b1 || fin_rise_data !== 8'h63) begin n_fail++; $display("FAIL abc_finish_rise: rises %0d dv %b data %h required 1 1 63", fin_rises, fin_rise_dv, fin_rise_data); end
    n_checks++; if (bus.finish_out !== 1'b0 || fin_viol !== 0) begin n_fail++; $display("FAIL abc_finish_hold: finish %b viol %0d required 0 0", bus.finish_out, fin_viol); end
    n_checks++; if (bus.digest !== 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100) begin n_fail++; $display("FAIL abc_digest: got %h", bus.digest); end
    n_checks++; if (bus.msg_len !== 64'd3 || bus.err !== 1'b0) begin n_fail++; $display("FAIL abc_len_err: len %0d err %b required 3 0", bus.msg_len, bus.err); end
    ack_digest();
    @(negedge clk);
    n_checks++; if (bus.digest_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abc_ack: digest_valid %b busy %b required 0 0", bus.digest_valid, bus.busy); end
  endtask

  task automatic test_stall();
    bit ok1, ok2;
    load_abc(); load_digest(W, 1'b0); clear_mon();
    send_msg(1'b0, 2, 4, ok1); send_digest(W - 1, 1'b1); wait_done(200, ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL stall_timeout: sent %b done %b required 1 1", ok1, ok2); end
    n_checks++; if (!stream_ok() || bus.msg_len !== 64'd3) begin n_fail++; $display("FAIL stall_bytes: %0d bytes, len %0d required 3 3", mon_bytes.size(), bus.msg_len); end
    n_checks++; if (stall_viol !== 0 || (last_dv - first_dv) !== 6) begin n_fail++; $display("FAIL stall_gap: viol %0d span %0d required 0 6", stall_viol, last_dv - first_dv); end
    n_checks++; if (bus.digest !== exp_digest(W - 1) || bus.err !== 1'b0) begin n_fail++; $display("FAIL stall_digest: got %h err %b", bus.digest, bus.err); end
    ack_digest();
  endtask

  task automatic test_zero_len();
    bit ok1, ok2;
    msg_q.delete(); msg_q.push_back(mk(8'hEE, 1'b1, 1'b1));
    load_digest(W, 1'b0); clear_mon();
    send_msg(1'b1, -1, 0, ok1); send_digest(W - 1, 1'b1); wait_done(200, ok2);
    n_checks++; if (!(ok1 && ok2) || start_cnt !== 1) begin n_fail++; $display("FAIL zero_flow: sent %b done %b starts %0d", ok1, ok2, start_cnt); end
    n_checks++; if (mon_bytes.size() !== 0 || fin_rises !== 1 || fin_rise_dv !== 1'b0) begin n_fail++; $display("FAIL zero_finish: bytes %0d rises %0d dv %b required 0 1 0", mon_bytes.size(), fin_rises, fin_rise_dv); end
    n_checks++; if (bus.msg_len !== 64'd0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL zero_len_err: len %0d err %b required 0 0", bus.msg_len, bus.err); end
    n_checks++; if (bus.digest !== exp_digest(W - 1)) begin n_fail++; $display("FAIL zero_digest: got %h required %h", bus.digest, exp_digest(W - 1)); end
    ack_digest();
  endtask

  task automatic test_short_digest();
    bit ok1, ok2;
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(mk(8'($urandom_range(0, 255)), i == 4, 1'b0));
    load_digest(10, 1'b0); clear_mon();
    send_msg(1'b1, -1, 0, ok1); send_digest(9, 1'b0); wait_done(100, ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL short_timeout: sent %b done %b required 1 1", ok1, ok2); end
    n_checks++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL short_err: got %b required 1", bus.err); end
    n_checks++; if (bus.digest !== exp_digest(9)) begin n_fail++; $display("FAIL short_digest: got %h required %h", bus.digest, exp_digest(9)); end
    n_checks++; if (bus.msg_len !== 64'd5) begin n_fail++; $display("FAIL short_len: got %0d required 5", bus.msg_len); end
    ack_digest();
  endtask

  task automatic test_mid_reset();
    bit ok1, ok2;
    msg_q.delete();
    msg_q.push_back(mk(8'h61, 1'b0, 1'b0));
    msg_q.push_back(mk(8'h62, 1'b0, 1'b0));
    clear_mon();
    send_msg(1'b0, -1, 0, ok1);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (!ok1 || bus.busy !== 1'b0 || bus.finish_out !== 1'b0 || bus.msg_len !== '0) begin n_fail++; $display("FAIL midrst_state: busy %b finish %b len %0d required 0 0 0", bus.busy, bus.finish_out, bus.msg_len); end
    clear_mon();
    repeat (5) @(negedge clk);
    n_checks++; if (start_cnt !== 0 || fin_rises !== 0) begin n_fail++; $display("FAIL midrst_quiet: starts %0d finishes %0d required 0 0", start_cnt, fin_rises); end
    load_abc(); load_digest(W, 1'b1); clear_mon();
    send_msg(1'b0, -1, 0, ok1); send_digest(W - 1, 1'b0); wait_done(100, ok2);
    n_checks++; if (!(ok1 && ok2) || !stream_ok() || bus.msg_len !== 64'd3 || bus.err !== 1'b0) begin n_fail++; $display("FAIL midrst_abc: done %b bytes %0d len %0d err %b", ok2, mon_bytes.size(), bus.msg_len, bus.err); end
    n_checks++; if (bus.digest !== exp_digest(W - 1)) begin n_fail++; $display("FAIL midrst_digest: got %h", bus.digest); end
    ack_digest();
  endtask

  task automatic test_stray_hdv();
    bit ok1, ok2;
    @(posedge clk); #1; bus.hdv_in = 1'b1; bus.hd_in = 8'hA7;
    @(posedge clk); #1; bus.hdv_in = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.digest !== '0 && bus.digest[7:0] === 8'hA7) begin n_fail++; $display("FAIL stray_err: err %b busy %b required 1 0", bus.err, bus.busy); end
    load_abc(); load_digest(W, 1'b0); clear_mon();
    send_msg(1'b0, -1, 0, ok1); send_digest(W - 1, 1'b0); wait_done(100, ok2);
    n_checks++; if (!(ok1 && ok2) || bus.err !== 1'b0) begin n_fail++; $display("FAIL stray_clear: done %b err %b required 1 0", ok2, bus.err); end
    ack_digest();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    msg_q.delete(); msg_q.push_back(mk(8'h5A, 1'b1, 1'b0));
    load_digest(W, 1'b0);
    send_msg(1'b0, -1, 0, ok1); send_digest(W - 1, 1'b0); wait_done(100, ok2);
    clear_mon();
    @(posedge clk); #1;
    bus.digest_ack = 1'b1; bus.s_valid = 1'b1; bus.s_data = 8'hA5; bus.s_last = 1'b1; bus.s_empty = 1'b0;
    @(posedge clk); #1; bus.digest_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (!(ok1 && ok2) || bus.busy !== 1'b0 || bus.start_out !== 1'b0 || bus.digest_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: busy %b start %b dvalid %b required 0 0 0", bus.busy, bus.start_out, bus.digest_valid); end
    @(negedge clk);
    n_checks++; if (bus.start_out !== 1'b1) begin n_fail++; $display("FAIL b2b_start: got %b required 1", bus.start_out); end
    msg_q.delete(); msg_q.push_back(mk(8'hA5, 1'b1, 1'b0));
    load_digest(W, 1'b0);
    send_msg(1'b0, -1, 0, ok1); send_digest(W - 1, 1'b0); wait_done(100, ok2);
    n_checks++; if (!(ok1 && ok2) || start_cnt !== 1 || !stream_ok() || bus.msg_len !== 64'd1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL b2b_second: starts %0d bytes %0d len %0d err %b", start_cnt, mon_bytes.size(), bus.msg_len, bus.err); end
    ack_digest();
  endtask

  task automatic test_random();
    bit ok1, ok2;
    int n, hend_i;
    for (int t = 0; t < 10; t++) begin
      msg_q.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 7) == 0) msg_q.push_back(mk(8'($urandom_range(0, 255)), 1'b0, 1'b1));
        msg_q.push_back(mk(8'($urandom_range(0, 255)), 1'b0, 1'b0));
      end
      if (n == 0 || $urandom_range(0, 3) == 0) msg_q.push_back(mk(8'($urandom_range(0, 255)), 1'b1, 1'b1));
      else msg_q[msg_q.size() - 1].last = 1'b1;
      hend_i = ($urandom_range(0, 9) < 7) ? W - 1 : int'($urandom_range(0, W + 3));
      load_digest(hend_i + 1, 1'b0); clear_mon();
      send_msg(1'b1, -1, 0, ok1); send_digest(hend_i, 1'b1); wait_done(300, ok2);
      n_checks++; if (!(ok1 && ok2) || start_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_flow: sent %b done %b starts %0d", t, ok1, ok2, start_cnt); end
      n_checks++; if (!stream_ok() || bus.msg_len !== exp_len()) begin n_fail++; $display("FAIL rand%0d_stream: bytes %0d len %0d required %0d", t, mon_bytes.size(), bus.msg_len, exp_len()); end
      n_checks++; if (bus.err !== (exp_msg_err() || hend_i != W - 1)) begin n_fail++; $display("FAIL rand%0d_err: got %b required %b", t, bus.err, exp_msg_err() || hend_i != W - 1); end
      n_checks++; if (bus.digest !== exp_digest(hend_i)) begin n_fail++; $display("FAIL rand%0d_digest: got %h required %h", t, bus.digest, exp_digest(hend_i)); end
      ack_digest();
    end
  endtask

  task automatic test_timeout();
    bit ok1, ok2;
    load_abc(); clear_mon();
    send_msg(1'b0, -1, 0, ok1);
`ifdef BLAKE_MSG_HOST_TIMEOUT_EN
    wait_done(TO + 10, ok2);
    n_checks++; if (!(ok1 && ok2) || bus.err !== 1'b1 || bus.finish_out !== 1'b0) begin n_fail++; $display("FAIL timeout_done: done %b err %b finish %b required 1 1 0", ok2, bus.err, bus.finish_out); end
    n_checks++; if (bus.digest !== '0) begin n_fail++; $display("FAIL timeout_digest: got %h required 0", bus.digest); end
    ack_digest();
`else
    ok2 = 1'b0;
    repeat (TO * 3) @(negedge clk);
    n_checks++; if (!ok1 || bus.digest_valid !== 1'b0 || bus.finish_out !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL no_timeout_wait: dvalid %b finish %b busy %b required 0 1 1", bus.digest_valid, bus.finish_out, bus.busy); end
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ok2 || bus.busy !== 1'b0 || bus.finish_out !== 1'b0) begin n_fail++; $display("FAIL no_timeout_abort: busy %b finish %b required 0 0", bus.busy, bus.finish_out); end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    bus.s_data = 8'h00; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_empty = 1'b0;
    bus.drdy_in = 1'b1; bus.hd_in = 8'h00; bus.hdv_in = 1'b0; bus.hend_in = 1'b0;
    bus.digest_ack = 1'b0;
    clear_mon();
    test_reset();
    test_abc();
    test_stall();
    test_zero_len();
    test_short_digest();
    test_mid_reset();
    test_stray_hdv();
    test_back_to_back();
    test_random();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
